// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 hex keypad column scanner with row synchronizer and per-key frame debounce
module keypad_scan #(
  parameter int SETTLE_CYCLES  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] keypad_matrix,
  output logic        scan_done
);

  localparam int PHASE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

  // Reject settle times that cannot cover the synchronizer plus one cycle of line settle.
  if (SETTLE_CYCLES < 3) begin : g_settle_check
    $error("keypad_scan: SETTLE_CYCLES must be at least 3");
  end

  // A key must be allowed to flip after at least one disagreeing frame.
  if (DEBOUNCE_SCANS < 1) begin : g_debounce_check
    $error("keypad_scan: DEBOUNCE_SCANS must be at least 1");
  end

  logic [3:0]               sync1_q, sync1_d;
  logic [3:0]               sync2_q, sync2_d;
  logic [PHASE_W-1:0]       phase_q, phase_d;
  logic [1:0]               col_q, col_d;
  logic [11:0]              raw_q, raw_d;
  logic [3:0]               col_n_q, col_n_d;
  logic [15:0]              matrix_q, matrix_d;
  logic                     scan_done_q, scan_done_d;
  logic [15:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]  row;
  logic        sample;
  logic        frame_end;
  logic [3:0]  c0, c1, c2, c3;
  logic [15:0] pressed_now;

  // Two-flop synchronizer on the asynchronous rows; inverted so 1 means row pulled low.
  always_comb begin
    sync1_d = row_n;
    sync2_d = sync1_q;
    row     = ~sync2_q;
  end

  // Column/phase counters: hold each column, then sample its rows and advance.
  always_comb begin
    sample    = (phase_q == PHASE_MAX);
    frame_end = sample && (col_q == 2'd3);
    phase_d   = sample ? '0 : phase_q + PHASE_W'(1);
    col_d     = sample ? col_q + 2'd1 : col_q;
    raw_d     = raw_q;
    if (sample) begin
      case (col_q)
        2'd0:    raw_d[3:0]  = row;
        2'd1:    raw_d[7:4]  = row;
        2'd2:    raw_d[11:8] = row;
        default: raw_d       = raw_q;
      endcase
    end
    // Drive register lags the column counter by one cycle so the first
    // column appears on the first edge after reset and every column is
    // held for the full SETTLE_CYCLES+1 cycles.
    col_n_d = ~(4'b0001 << col_q);
  end

  // Remap (row, column) samples to hex-labelled key bits; column 3 uses the live row.
  always_comb begin
    c0 = raw_q[3:0];
    c1 = raw_q[7:4];
    c2 = raw_q[11:8];
    c3 = row;
    pressed_now      = '0;
    pressed_now[1]   = c0[0];
    pressed_now[2]   = c1[0];
    pressed_now[3]   = c2[0];
    pressed_now[12]  = c3[0];
    pressed_now[4]   = c0[1];
    pressed_now[5]   = c1[1];
    pressed_now[6]   = c2[1];
    pressed_now[13]  = c3[1];
    pressed_now[7]   = c0[2];
    pressed_now[8]   = c1[2];
    pressed_now[9]   = c2[2];
    pressed_now[14]  = c3[2];
    pressed_now[10]  = c0[3];
    pressed_now[0]   = c1[3];
    pressed_now[11]  = c2[3];
    pressed_now[15]  = c3[3];
  end

  // Per-key debounce at frame end: flip only after DEBOUNCE_SCANS consecutive disagreeing frames.
  always_comb begin
    matrix_d    = matrix_q;
    cnt_d       = cnt_q;
    scan_done_d = frame_end;
    if (frame_end) begin
      for (int k = 0; k < 16; k++) begin
        if (pressed_now[k] == matrix_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          matrix_d[k] = pressed_now[k];
          cnt_d[k]    = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset clears all scan and debounce history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      phase_q     <= '0;
      col_q       <= '0;
      raw_q       <= '0;
      col_n_q     <= 4'hF;
      matrix_q    <= '0;
      scan_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      raw_q       <= raw_d;
      col_n_q     <= col_n_d;
      matrix_q    <= matrix_d;
      scan_done_q <= scan_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign col_n         = col_n_q;
  assign keypad_matrix = matrix_q;
  assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with a physical keypad model and frame-level debounce reference
module tb_keypad_scan;

  localparam int DB    = 4;
  localparam int FRAME = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keypad_matrix;
  logic        scan_done;

  logic [15:0] held = 16'h0000;
  logic [15:0] exp_mat;
  int          exp_cnt[16];
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SETTLE_CYCLES(15), .DEBOUNCE_SCANS(DB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_n         (row_n),
    .col_n         (col_n),
    .keypad_matrix (keypad_matrix),
    .scan_done     (scan_done)
  );

  function automatic int key_label(input int r, input int c);
    case (r * 4 + c)
      0: return 1;   1: return 2;   2: return 3;   3: return 12;
      4: return 4;   5: return 5;   6: return 6;   7: return 13;
      8: return 7;   9: return 8;  10: return 9;  11: return 14;
      12: return 10; 13: return 0;  14: return 11; default: return 15;
    endcase
  endfunction

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_n[c] == 1'b0 && held[key_label(r, c)]) row_n[r] = 1'b0;
  end

  task automatic model_reset();
    exp_mat = 16'h0000;
    for (int k = 0; k < 16; k++) exp_cnt[k] = 0;
  endtask

  // One frame of the reference: a key flips after DB consecutive frames of disagreement.
  task automatic model_frame(input logic [15:0] pn);
    for (int k = 0; k < 16; k++) begin
      if (pn[k] == exp_mat[k]) exp_cnt[k] = 0;
      else if (exp_cnt[k] + 1 >= DB) begin
        exp_mat[k] = pn[k];
        exp_cnt[k] = 0;
      end else exp_cnt[k] = exp_cnt[k] + 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!scan_done && cycles < 200);
    if (!scan_done) begin
      n_checks++;
      $display("FAIL wait_frame: no scan_done within %0d cycles", cycles);
    end
    model_frame(held);
  endtask

  task automatic test_reset();
    int cyc;
    int col_err;
    int sd_err;
    logic [3:0] exp_col;
    held = 16'h0001;
    do_reset();
    for (int f = 0; f < 5; f++) wait_frame(cyc);
    repeat (21) @(posedge clk);
    #3 rst_n = 1'b0;
    held = 16'h0000;
    #1;
    n_checks++;
    if (col_n !== 4'hF) $display("FAIL reset_col_n: got %h want F", col_n); else n_pass++;
    n_checks++;
    if (keypad_matrix !== 16'h0000) $display("FAIL reset_matrix: got %h want 0000", keypad_matrix); else n_pass++;
    n_checks++;
    if (scan_done !== 1'b0) $display("FAIL reset_scan_done: got %b want 0", scan_done); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    col_err = 0;
    sd_err = 0;
    for (int i = 1; i <= 140; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << (((i - 1) / 16) % 4));
      if (col_n !== exp_col) col_err++;
      if (scan_done !== ((i % FRAME) == 0)) sd_err++;
    end
    n_checks++;
    if (col_err != 0) $display("FAIL col_sequence: %0d wrong cycles, want 0", col_err); else n_pass++;
    n_checks++;
    if (sd_err != 0) $display("FAIL scan_done_period: %0d wrong cycles, want 0", sd_err); else n_pass++;
  endtask

  task automatic test_single_press();
    int cyc;
    held = 16'h0001;
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      wait_frame(cyc);
      n_checks++;
      if (keypad_matrix !== exp_mat) $display("FAIL single_press frame %0d: got %h want %h", f, keypad_matrix, exp_mat); else n_pass++;
      if (f == 3) begin
        n_checks++;
        if (keypad_matrix !== 16'h0000) $display("FAIL single_press_early: got %h want 0000", keypad_matrix); else n_pass++;
      end
      if (f == 4) begin
        n_checks++;
        if (keypad_matrix !== 16'h0001) $display("FAIL single_press_set: got %h want 0001", keypad_matrix); else n_pass++;
        n_checks++;
        if (cyc != FRAME) $display("FAIL single_press_period: got %0d want %0d", cyc, FRAME); else n_pass++;
      end
    end
  endtask

  task automatic test_bounce();
    int cyc;
    held = 16'h0020;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      held = (i == 3) ? 16'h0000 : 16'h0020;
      wait_frame(cyc);
      n_checks++;
      if (keypad_matrix !== 16'h0000) $display("FAIL bounce frame %0d: got %h want 0000", i, keypad_matrix); else n_pass++;
    end
  endtask

  task automatic test_release();
    int cyc;
    int frames;
    int per_err;
    held = 16'h8000;
    do_reset();
    frames = 0;
    while (keypad_matrix[15] !== 1'b1 && frames < 8) begin
      wait_frame(cyc);
      frames++;
    end
    n_checks++;
    if (frames != DB) $display("FAIL release_press_frames: got %0d want %0d", frames, DB); else n_pass++;
    held = 16'h0000;
    per_err = 0;
    for (int f = 1; f <= 4; f++) begin
      wait_frame(cyc);
      if (cyc != FRAME) per_err++;
      n_checks++;
      if (keypad_matrix[15] !== (f < 4)) $display("FAIL release frame %0d: got bit15=%b want %b", f, keypad_matrix[15], (f < 4)); else n_pass++;
    end
    n_checks++;
    if (per_err != 0) $display("FAIL release_period: %0d irregular frames, want 0", per_err); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int cyc;
    held = 16'h8002;
    do_reset();
    for (int f = 0; f < 4; f++) wait_frame(cyc);
    n_checks++;
    if (keypad_matrix !== 16'h8002) $display("FAIL simul_both: got %h want 8002", keypad_matrix); else n_pass++;
    held = 16'h8000;
    for (int f = 1; f <= 4; f++) begin
      wait_frame(cyc);
      n_checks++;
      if (keypad_matrix !== exp_mat) $display("FAIL simul_release frame %0d: got %h want %h", f, keypad_matrix, exp_mat); else n_pass++;
    end
    n_checks++;
    if (keypad_matrix !== 16'h8000) $display("FAIL simul_one: got %h want 8000", keypad_matrix); else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    int cyc;
    held = 16'h1000;
    do_reset();
    for (int f = 0; f < 3; f++) wait_frame(cyc);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (keypad_matrix !== 16'h0000 || col_n !== 4'hF) $display("FAIL mid_reset_outputs: got %h/%h want 0000/F", keypad_matrix, col_n); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int f = 1; f <= 4; f++) begin
      wait_frame(cyc);
      n_checks++;
      if (keypad_matrix !== ((f == 4) ? 16'h1000 : 16'h0000))
        $display("FAIL mid_reset frame %0d: got %h want %h", f, keypad_matrix, (f == 4) ? 16'h1000 : 16'h0000);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int cyc;
    held = 16'($urandom) & 16'($urandom);
    do_reset();
    for (int f = 0; f < 40; f++) begin
      wait_frame(cyc);
      n_checks++;
      if (keypad_matrix !== exp_mat) $display("FAIL random frame %0d: got %h want %h", f, keypad_matrix, exp_mat); else n_pass++;
      if ($urandom_range(0, 3) == 0) held = 16'($urandom) & 16'($urandom);
      else if ($urandom_range(0, 3) == 0) held = held ^ (16'h0001 << $urandom_range(0, 15));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
